// File: rtl/bsg_alu_resp.sv
// Flow-controlled two-stage ALU responder: S1 operand register, S2 compute into
// a credit-protected output FIFO, results tagged with a wrapping sequence number.
module bsg_alu_resp #(
  parameter int unsigned width_p     = 4,
  parameter int unsigned els_p       = 2,
  parameter int unsigned tag_width_p = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   v_i,
  input  logic [1:0]             control_i,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [width_p-1:0]     res_o,
  output logic                   carry_o,
  output logic                   zero_o,
  output logic [tag_width_p-1:0] tag_o,
  input  logic                   yumi_i
);

  localparam int unsigned ptr_w = $clog2(els_p);
  localparam int unsigned cnt_w = $clog2(els_p + 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef struct packed {
    logic [width_p-1:0]     res;
    logic                   carry;
    logic                   zero;
    logic [tag_width_p-1:0] tag;
  } entry_t;

  logic                   s1_v;
  op_e                    s1_op;
  logic [width_p-1:0]     s1_a, s1_b;
  logic [tag_width_p-1:0] s1_tag, tag_r;

  entry_t                 mem [els_p];
  logic [ptr_w-1:0]       wr_ptr, rd_ptr;
  logic [cnt_w-1:0]       count;

  entry_t                 s2_entry, head;
  logic [width_p:0]       wide_sum, wide_diff;
  logic [cnt_w:0]         occupancy;
  logic                   accept, enq, deq;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_comb begin
    wide_sum  = {1'b0, s1_a} + {1'b0, s1_b};
    wide_diff = {1'b0, s1_a} - {1'b0, s1_b};
    s2_entry  = '0;
    unique case (s1_op)
      OP_ADD: begin s2_entry.res = wide_sum[width_p-1:0];  s2_entry.carry = wide_sum[width_p];  end
      // The borrow out of the widened subtract is exactly a < b (unsigned).
      OP_SUB: begin s2_entry.res = wide_diff[width_p-1:0]; s2_entry.carry = wide_diff[width_p]; end
      OP_AND: s2_entry.res = s1_a & s1_b;
      OP_OR:  s2_entry.res = s1_a | s1_b;
      default: s2_entry.res = '0;
    endcase
    s2_entry.zero = (s2_entry.res == '0);
    s2_entry.tag  = s1_tag;
  end

  // Credit counts S1 as already occupying a FIFO slot, so S1->FIFO never stalls.
  assign occupancy = {1'b0, count} + (cnt_w + 1)'(s1_v);
  assign ready_o   = !reset && (occupancy < (cnt_w + 1)'(els_p));
  assign v_o       = (count != '0);
  assign accept    = v_i && ready_o;
  assign enq       = s1_v;
  assign deq       = yumi_i && v_o;

  assign head    = mem[rd_ptr];
  assign res_o   = head.res;
  assign carry_o = head.carry;
  assign zero_o  = head.zero;
  assign tag_o   = head.tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v   <= 1'b0;
      s1_op  <= OP_ADD;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
      tag_r  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < els_p; i++) begin
        mem[i] <= '{res: '0, carry: 1'b0, zero: 1'b1, tag: '0};
      end
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_op  <= op_e'(control_i);
        s1_a   <= a_i;
        s1_b   <= b_i;
        s1_tag <= tag_r;
        tag_r  <= tag_r + tag_width_p'(1);
      end
      if (enq) begin
        mem[wr_ptr] <= s2_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(yumi_i && !v_o)) else $error("bsg_alu_resp: yumi_i asserted while v_o is low");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_alu_resp.sv
// Scoreboard bench for bsg_alu_resp: the driver pushes hand-computed results on
// accept, an independent monitor pops and compares on each dequeue.
module tb_bsg_alu_resp;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  typedef struct packed {
    logic [3:0] res;
    logic       c;
    logic       z;
    logic [7:0] tag;
  } exp_t;

  logic       clk, reset, v_i, ready_o, v_o, carry_o, zero_o, yumi_i, yumi_en;
  logic [1:0] control_i;
  logic [3:0] a_i, b_i, res_o;
  logic [7:0] tag_o;

  exp_t       sb[$];
  logic [7:0] exp_tag;
  int         checks, errors, accepts, cycle;

  bsg_alu_resp #(.width_p(4), .els_p(2), .tag_width_p(8)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .control_i(control_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready_o), .v_o(v_o), .res_o(res_o), .carry_o(carry_o), .zero_o(zero_o),
    .tag_o(tag_o), .yumi_i(yumi_i)
  );

  // Consumer only takes the head when one is presented.
  assign yumi_i = yumi_en && v_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: compares the head against the scoreboard on every dequeue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && v_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_v_o tag=%0d with no outstanding request", tag_o);
        end else if (yumi_i) begin
          e = sb.pop_front();
          checks++;
          if ({res_o, carry_o, zero_o, tag_o} !== e) begin
            errors++;
            $display("FAIL result got res=%0d c=%0d z=%0d tag=%0d want res=%0d c=%0d z=%0d tag=%0d",
                     res_o, carry_o, zero_o, tag_o, e.res, e.c, e.z, e.tag);
          end
        end
      end
    end
  end

  // Starts and ends at posedge+1; expected value is pushed when the accept is certain.
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] res, input logic c);
    v_i = 1'b1; control_i = op; a_i = a; b_i = b;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready_o) begin
        sb.push_back('{res: res, c: c, z: (res == 4'd0), tag: exp_tag});
        exp_tag++;
        @(posedge clk); #1;
        v_i = 1'b0;
        accepts++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout got no ready_o want ready_o=1 within 200 cycles");
    v_i = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !v_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; v_i = 1'b0; yumi_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready_o, 0);
    check("rst_v",     v_o,     0);
    check("rst_res",   res_o,   0);
    check("rst_carry", carry_o, 0);
    check("rst_zero",  zero_o,  1);
    check("rst_tag",   tag_o,   0);
    sb.delete();
    exp_tag = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready_o, 1);
    check("post_rst_v",     v_o,     0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc0, start;
    checks = 0; errors = 0; accepts = 0; cycle = 0; exp_tag = '0;
    v_i = 1'b0; control_i = ADD; a_i = '0; b_i = '0; yumi_en = 1'b0; reset = 1'b1;

    reset_dut();

    // Arithmetic stream with the consumer always taking.
    yumi_en = 1'b1;
    issue(ADD,  1,  3,  4, 0);
    issue(SUB,  1,  3, 14, 1);
    issue(ADD, 15,  1,  0, 1);
    issue(AND, 12, 10,  8, 0);
    issue(OR,  12, 10, 14, 0);
    drain();

    // Latency: accept at edge N, v_o low after N, high after N+1.
    reset_dut();
    yumi_en = 1'b1;
    issue(ADD, 2, 2, 4, 0);
    @(negedge clk);
    check("lat_v_early", v_o, 0);
    @(negedge clk);
    check("lat_v", v_o, 1);
    check("lat_res", res_o, 4);
    @(posedge clk); #1;

    // Eight streamed ops, tags 1..8.
    start = cycle;
    for (int i = 0; i < 8; i++) issue(ADD, 4'(i), 4'd1, 4'(i + 1), 0);
    check("stream_cycles_le16", (cycle - start) <= 16, 1);
    drain();

    // Backpressure: consumer stalled, three requests offered, two fit.
    yumi_en = 1'b0;
    acc0 = accepts;
    fork
      begin
        issue(AND, 3, 5, 1, 0);
        issue(OR,  3, 5, 7, 0);
        issue(SUB, 5, 3, 2, 0);
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("bp_accepts", accepts - acc0, 2);
    check("bp_ready",   ready_o, 0);
    check("bp_v",       v_o, 1);
    check("bp_head_tag", tag_o, 9);
    yumi_en = 1'b1;
    for (int n = 0; n < 50 && (accepts - acc0) < 3; n++) @(posedge clk);
    #1;
    check("bp_third_accepted", accepts - acc0, 3);
    drain();

    // Simultaneous enqueue and dequeue: FIFO holds 1, S1 valid.
    reset_dut();
    yumi_en = 1'b0;
    issue(ADD, 3, 4, 7, 0);
    issue(OR,  5, 2, 7, 0);
    yumi_en = 1'b1;
    @(negedge clk);
    check("sim_v",     v_o, 1);
    check("sim_tag0",  tag_o, 0);
    check("sim_ready", ready_o, 0);
    @(posedge clk); #1;
    yumi_en = 1'b0;
    @(negedge clk);
    check("sim_v_after",     v_o, 1);
    check("sim_tag1",        tag_o, 1);
    check("sim_ready_after", ready_o, 1);
    @(posedge clk); #1;
    yumi_en = 1'b1;
    drain();

    // Reset with results in flight; first result afterwards carries tag 0.
    yumi_en = 1'b0;
    issue(ADD, 1, 1, 2, 0);
    issue(ADD, 2, 2, 4, 0);
    check("mid_ready_full", ready_o, 0);
    reset_dut();
    yumi_en = 1'b1;
    issue(ADD, 0, 0, 0, 0);
    drain();

    // Tag wrap: 257 ops, tags 0..255 then 0.
    reset_dut();
    yumi_en = 1'b1;
    for (int i = 0; i < 257; i++) issue(AND, 4'(i), 4'd15, 4'(i), 0);
    drain();
    check("wrap_exp_tag", exp_tag, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
